// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front-end of the 256x8 SPI RAM.
package spi_slave_pkg;

  localparam int FRAME_W_DEF = 10;
  localparam int DATA_W_DEF  = 8;

  // cmd field values; forwarded untouched, decoded by the RAM
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

endpackage

// File: rtl/spi_slave_miso_ser.sv
// Parallel-load MISO serialiser: load presents the MSB at once, each shift emits
// the next bit, and one shift after the LSB the line returns to 0 and holds.
module spi_slave_miso_ser
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              miso_q, miso_d;

  // cnt_q = bits still owed on the line, including the one currently driven
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    miso_d = miso_q;
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
      miso_d = 1'b0;
    end else if (load) begin
      sreg_d = data << 1;
      cnt_d  = CW'(DATA_W);
      miso_d = data[DATA_W-1];
    end else if (shift && cnt_q != '0) begin
      miso_d = (cnt_q == CW'(1)) ? 1'b0 : sreg_q[DATA_W-1];
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;
  assign done = (cnt_q == '0);

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end: deserialises 10-bit MOSI frames for the RAM and
// returns RAM read data on MISO. Define SPI_SLAVE_ABORT_EN to add frame_abort.
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
`ifdef SPI_SLAVE_ABORT_EN
  output logic               frame_abort,
`endif
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(FRAME_W - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_done_q, rd_addr_done_d;
  logic               tx_sent_q, tx_sent_d;
  logic               ser_load, ser_clr, ser_done;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    frame_d        = frame_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    tx_sent_d      = tx_sent_q;
    ser_load       = 1'b0;
    ser_clr        = 1'b0;
    case (state_q)
      IDLE: if (!ss_n) state_d = CHK_CMD;
      CHK_CMD: begin
        frame_d = {{(FRAME_W-1){1'b0}}, mosi};
        cnt_d   = '0;
        state_d = !mosi ? WRITE : (rd_addr_done_q ? READ_DATA : READ_ADD);
      end
      default: begin
        if (cnt_q < CNT_LAST) begin
          frame_d = {frame_q[FRAME_W-2:0], mosi};
          cnt_d   = cnt_q + CNT_W'(1);
        end
        // this edge samples bit 0: publish the frame and update the read flag
        if (cnt_q == CNT_PRE) begin
          rx_data_d  = frame_d;
          rx_valid_d = 1'b1;
          if (state_q == READ_ADD)  rd_addr_done_d = 1'b1;
          if (state_q == READ_DATA) rd_addr_done_d = 1'b0;
        end
        if (state_q == READ_DATA && cnt_q == CNT_LAST && !tx_sent_q && tx_valid) begin
          ser_load  = 1'b1;
          tx_sent_d = 1'b1;
        end
      end
    endcase
    // ss_n high ends any frame; completion on this same edge was already taken above
    if (state_q != IDLE && ss_n) begin
      state_d   = IDLE;
      cnt_d     = '0;
      tx_sent_d = 1'b0;
      ser_load  = 1'b0;
      ser_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frame_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_sent_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_sent_q      <= tx_sent_d;
    end
  end

  spi_slave_miso_ser #(.DATA_W(DATA_W)) u_miso_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ser_clr),
    .load  (ser_load),
    .shift (!ser_done),
    .data  (tx_data),
    .miso  (miso),
    .done  (ser_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_ABORT_EN
  logic abort_q, abort_d;
  // bit 0 not yet sampled when ss_n rises
  assign abort_d = ss_n && ((state_q == CHK_CMD) ||
                   ((state_q inside {WRITE, READ_ADD, READ_DATA}) && cnt_q < CNT_PRE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abort_q <= 1'b0;
    else        abort_q <= abort_d;
  end

  assign frame_abort = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frames, read-back through a small RAM model,
// aborts, mid-frame reset and back-to-back frames.
module tb_spi_slave_if;
  import spi_slave_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ss_n, mosi, miso, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
`ifdef SPI_SLAVE_ABORT_EN
  logic       frame_abort;
`endif

  int checks = 0;
  int errors = 0;
  int vld_total = 0;
  logic [7:0] mem [256];
  logic [7:0] wa, ra;

  always #5 clk = ~clk;

  // rx_valid is stable across the posedge it is counted at
  always @(posedge clk) if (rx_valid) vld_total <= vld_total + 1;

  spi_slave_if dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
`ifdef SPI_SLAVE_ABORT_EN
    .frame_abort (frame_abort),
`endif
    .tx_data     (tx_data),
    .tx_valid    (tx_valid)
  );

  // Called at a negedge; drops ss_n now, drives the first n frame bits MSB
  // first, and returns at the negedge after the edge that sampled the last one.
  task automatic drive_bits(input logic [9:0] f, input int n);
    ss_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mosi = f[9-i];
    end
    @(negedge clk);
  endtask

  task automatic release_ss();
    ss_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data got %h exp 000", rx_data); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state_q); end
    checks++; if (dut.rd_addr_done_q !== 1'b0) begin errors++; $display("FAIL reset_rd_done got %b exp 0", dut.rd_addr_done_q); end
`ifdef SPI_SLAVE_ABORT_EN
    checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b exp 0", frame_abort); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_addr();
    int v0;
    v0 = vld_total;
    drive_bits(10'b00_0101_0101, 10);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL wa_rx_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 10'h055) begin errors++; $display("FAIL wa_rx_data got %h exp 055", rx_data); end
    checks++; if (dut.state_q !== WRITE) begin errors++; $display("FAIL wa_state got %0d exp WRITE", dut.state_q); end
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL wa_pulse_len got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 10'h055) begin errors++; $display("FAIL wa_hold got %h exp 055", rx_data); end
    release_ss();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL wa_idle got %0d exp IDLE", dut.state_q); end
    checks++; if (vld_total - v0 !== 1) begin errors++; $display("FAIL wa_pulse_count got %0d exp 1", vld_total - v0); end
  endtask

  task automatic test_read_back();
    logic [7:0] exp_byte;
    exp_byte = 8'hA5;
    drive_bits(10'h010, 10);
    checks++; if (rx_data !== 10'h010) begin errors++; $display("FAIL rb_wr_addr got %h exp 010", rx_data); end
    wa = 8'h10;
    release_ss();
    drive_bits(10'h1A5, 10);
    checks++; if (rx_data !== 10'h1A5) begin errors++; $display("FAIL rb_wr_data got %h exp 1a5", rx_data); end
    mem[wa] = 8'hA5;
    // tx_valid outside the READ_DATA wait must not reach MISO
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rb_tx_ignored got %b exp 0", miso); end
    release_ss();
    drive_bits(10'h210, 10);
    checks++; if (rx_data !== 10'h210) begin errors++; $display("FAIL rb_rd_addr got %h exp 210", rx_data); end
    checks++; if (dut.state_q !== READ_ADD) begin errors++; $display("FAIL rb_state_ra got %0d exp READ_ADD", dut.state_q); end
    checks++; if (dut.rd_addr_done_q !== 1'b1) begin errors++; $display("FAIL rb_flag_set got %b exp 1", dut.rd_addr_done_q); end
    ra = 8'h10;
    release_ss();
    drive_bits(10'h300, 10);
    checks++; if (rx_data !== 10'h300) begin errors++; $display("FAIL rb_rd_data got %h exp 300", rx_data); end
    checks++; if (dut.state_q !== READ_DATA) begin errors++; $display("FAIL rb_state_rd got %0d exp READ_DATA", dut.state_q); end
    checks++; if (dut.rd_addr_done_q !== 1'b0) begin errors++; $display("FAIL rb_flag_clr got %b exp 0", dut.rd_addr_done_q); end
    tx_data = mem[ra]; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      checks++; if (miso !== exp_byte[i]) begin errors++; $display("FAIL rb_miso_bit%0d got %b exp %b", i, miso, exp_byte[i]); end
      @(negedge clk);
    end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rb_miso_tail got %b exp 0", miso); end
    @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rb_miso_hold got %b exp 0", miso); end
    release_ss();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rb_idle got %0d exp IDLE", dut.state_q); end
  endtask

  task automatic test_abort();
    int v0;
    v0 = vld_total;
    drive_bits(10'b00_1111_1111, 5);
    ss_n = 1'b1;
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ab_state got %0d exp IDLE", dut.state_q); end
    checks++; if (rx_data !== 10'h300) begin errors++; $display("FAIL ab_rx_data got %h exp 300", rx_data); end
`ifdef SPI_SLAVE_ABORT_EN
    checks++; if (frame_abort !== 1'b1) begin errors++; $display("FAIL ab_pulse got %b exp 1", frame_abort); end
`endif
    @(negedge clk);
`ifdef SPI_SLAVE_ABORT_EN
    checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL ab_pulse_len got %b exp 0", frame_abort); end
`endif
    checks++; if (vld_total - v0 !== 0) begin errors++; $display("FAIL ab_no_valid got %0d exp 0", vld_total - v0); end
  endtask

  task automatic test_rd_addr_abort();
    drive_bits(10'h233, 10);
    checks++; if (dut.rd_addr_done_q !== 1'b1) begin errors++; $display("FAIL ra_flag_set got %b exp 1", dut.rd_addr_done_q); end
    release_ss();
    drive_bits(10'h2FF, 3);
    ss_n = 1'b1;
    @(negedge clk);
    checks++; if (dut.rd_addr_done_q !== 1'b1) begin errors++; $display("FAIL ra_flag_kept got %b exp 1", dut.rd_addr_done_q); end
    checks++; if (rx_data !== 10'h233) begin errors++; $display("FAIL ra_rx_data got %h exp 233", rx_data); end
    drive_bits(10'h300, 1);
    checks++; if (dut.state_q !== READ_DATA) begin errors++; $display("FAIL ra_next_rd got %0d exp READ_DATA", dut.state_q); end
    release_ss();
  endtask

  task automatic test_reset_mid_read();
    drive_bits(10'h300, 10);
    tx_data = 8'hC3; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rr_miso_b7 got %b exp 1", miso); end
    @(negedge clk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rr_miso_b6 got %b exp 1", miso); end
    rst_n = 1'b0; ss_n = 1'b1;
    #1;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rr_miso got %b exp 0", miso); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rr_rx_valid got %b exp 0", rx_valid); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rr_state got %0d exp IDLE", dut.state_q); end
    checks++; if (dut.rd_addr_done_q !== 1'b0) begin errors++; $display("FAIL rr_flag got %b exp 0", dut.rd_addr_done_q); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_bits(10'h2AA, 1);
    checks++; if (dut.state_q !== READ_ADD) begin errors++; $display("FAIL rr_next_ra got %0d exp READ_ADD", dut.state_q); end
    release_ss();
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vld_total;
    drive_bits(10'h0AB, 10);
    checks++; if (rx_data !== 10'h0AB) begin errors++; $display("FAIL bb_first got %h exp 0ab", rx_data); end
    release_ss();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL bb_gap got %0d exp IDLE", dut.state_q); end
    drive_bits(10'h15C, 10);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL bb_second_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 10'h15C) begin errors++; $display("FAIL bb_second got %h exp 15c", rx_data); end
    release_ss();
    checks++; if (vld_total - v0 !== 2) begin errors++; $display("FAIL bb_pulses got %0d exp 2", vld_total - v0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_addr();
    test_read_back();
    test_abort();
    test_rd_addr_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
